cla_nibble_serial_ctrl: RTL and testbench

- Multi-cycle controller that performs a WIDTH-bit addition using one shared 4-bit carry-lookahead slice (CLA_4bit), one nibble per clock, least-significant nibble first.
- Carry is registered between nibbles.
- Accepts operands over a valid/ready handshake and returns the result over a second one.
- Sits between operand-producing logic and any consumer needing wide sums, where area matters more than latency.

---
 rtl/cla_nibble_serial_ctrl_pkg.sv | 22 ++
 rtl/cla_nibble_serial_ctrl_cla4.sv | 27 ++
 rtl/cla_nibble_serial_ctrl.sv | 147 ++++++++++++++
 tb/tb_cla_nibble_serial_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cla_nibble_serial_ctrl_pkg.sv
// Shared types and sizing helpers for the nibble-serial carry-lookahead adder.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

    function automatic int idx_width(input int width);
        int n;
        n = width / NIBBLE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_nibble_serial_ctrl_cla4.sv
// 4-bit carry-lookahead slice: all internal carries computed directly from generate/propagate.
module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_nibble_serial_ctrl.sv
// Nibble-serial WIDTH-bit adder reusing one CLA_4bit slice, LS nibble first.
// Optional subtraction is enabled by defining CLA_SERIAL_SUB_EN.
module cla_nibble_serial_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef CLA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N     = nibble_count(WIDTH);
    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic             cout_q;
    logic             ovf_q;

    logic accept;
    logic step;
    logic last;

    logic [NIBBLE_W-1:0] a_nib [N];
    logic [NIBBLE_W-1:0] b_nib [N];
    logic [NIBBLE_W-1:0] a_sel;
    logic [NIBBLE_W-1:0] b_sel;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs depend on registered state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
        accept    = (state == IDLE) && in_valid;
        step      = (state == RUN);
        last      = step && (idx == LAST_IDX);
    end

`ifdef CLA_SERIAL_SUB_EN
    assign b_load     = sub ? ~B : B;
    assign carry_load = sub ? 1'b1 : Cin;
`else
    assign b_load     = B;
    assign carry_load = Cin;
`endif

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_nib
            logic [NIBBLE_W-1:0] sum_nib;

            assign a_nib[gi] = a_q[gi*NIBBLE_W +: NIBBLE_W];
            assign b_nib[gi] = b_q[gi*NIBBLE_W +: NIBBLE_W];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sum_nib <= '0;
                end else if (step && (idx == IDX_W'(gi))) begin
                    sum_nib <= slice_sum;
                end
            end

            assign Sum[gi*NIBBLE_W +: NIBBLE_W] = sum_nib;
        end
    endgenerate

    assign a_sel = a_nib[idx];
    assign b_sel = b_nib[idx];

    CLA_4bit u_slice (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= b_load;
            carry_q <= carry_load;
            idx     <= '0;
        end else if (step) begin
            carry_q <= slice_cout;
            idx     <= last ? '0 : idx + 1'b1;
            if (last) begin
                cout_q <= slice_cout;
                // Overflow: like-signed operands producing a result of the other sign.
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign Cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_serial_ctrl.sv
// Directed self-checking bench for cla_nibble_serial_ctrl at WIDTH=16.
module tb_cla_nibble_serial_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef CLA_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             ovf;
    logic             busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cla_nibble_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef CLA_SERIAL_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, measure latency, check result, optionally hold back-pressure.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic do_sub, input logic [15:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf, input int hold);
        int cycles;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A = a; B = b; Cin = cin; in_valid = 1'b1;
`ifdef CLA_SERIAL_SUB_EN
        sub = do_sub;
`endif
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = ~a; B = ~b; Cin = ~cin;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'd4);
        check({tag, "_sum"}, 32'(Sum), 32'(exp_sum));
        check({tag, "_cout_ovf"}, {30'd0, Cout, ovf}, {30'd0, exp_cout, exp_ovf});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A = 16'hAAAA; B = 16'h5555;
            @(negedge clk);
            check({tag, "_hold"}, {Sum, 11'd0, out_valid, in_ready, busy, Cout, ovf},
                  {exp_sum, 11'd0, 1'b1, 1'b0, 1'b1, exp_cout, exp_ovf});
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_release"}, {29'd0, in_ready, out_valid, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
        $display("op %s: A=%h B=%h Cin=%b sub=%b -> Sum=%h Cout=%b ovf=%b latency=%0d",
                 tag, a, b, cin, do_sub, exp_sum, exp_cout, exp_ovf, cycles);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; out_ready = 1'b1;
`ifdef CLA_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {Sum, 11'd0, in_ready, out_valid, busy, Cout, ovf},
              {16'h0000, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;

        do_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        do_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        do_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        do_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        do_op("add_00ff_cin",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
        do_op("backpressure",  16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 5);

        // Reset while idx==2: accept edge, then two RUN edges, then reset.
        @(negedge clk);
        A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_reset", {Sum, 11'd0, in_ready, out_valid, busy, Cout, ovf},
              {16'h0000, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrun_no_result", {30'd0, out_valid, busy}, 32'd0);
        end
        $display("op midrun_reset: in-flight operation discarded");
        do_op("add_0001_0002", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 0);

`ifdef CLA_SERIAL_SUB_EN
        do_op("sub_0005_0007", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        do_op("sub_0007_0005", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 0);
        do_op("sub0_add",      16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
